// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: HDMI scan-out burst reads vs. camera single-word writes.
// Reads have priority; a write that has waited WR_MAX_WAIT cycles overrides it at the next IDLE.
module fb_mem_arbiter #(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned WR_MAX_WAIT = 64
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WAIT_W = $clog2(WR_MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR} state_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t            state, state_nxt;
  mem_cmd_t          cmd, cmd_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hs;
  logic              wr_starved;

  assign hs         = cmd.valid & mem_cmd_ready;
  assign wr_starved = (wait_cnt >= WAIT_W'(WR_MAX_WAIT));

  assign mem_cmd_valid = cmd.valid;
  assign mem_we        = cmd.we;
  assign mem_addr      = cmd.addr;
  assign mem_wdata     = cmd.wdata;

  always_ff @(posedge clk_low) begin
    if (!reset) begin
      state <= IDLE;
      cmd   <= '0;
      beat  <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      cmd   <= cmd_nxt;
      beat  <= beat_nxt;
      base  <= base_nxt;
    end
  end

  // The command register is loaded with the next command, so mem_* never
  // depend combinationally on the requester inputs.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    beat_nxt  = beat;
    base_nxt  = base;
    rd_grant  = 1'b0;
    wr_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && wr_starved) begin
          state_nxt     = WR;
          cmd_nxt.valid = 1'b1;
          cmd_nxt.we    = 1'b1;
          cmd_nxt.addr  = wr_addr;
          cmd_nxt.wdata = wr_data;
        end else if (rd_req) begin
          rd_grant      = 1'b1;
          base_nxt      = rd_addr;
          beat_nxt      = '0;
          state_nxt     = RD_BURST;
          cmd_nxt.valid = 1'b1;
          cmd_nxt.we    = 1'b0;
          cmd_nxt.addr  = rd_addr;
        end else if (wr_req) begin
          state_nxt     = WR;
          cmd_nxt.valid = 1'b1;
          cmd_nxt.we    = 1'b1;
          cmd_nxt.addr  = wr_addr;
          cmd_nxt.wdata = wr_data;
        end
      end
      RD_BURST: begin
        if (hs) begin
          if (beat == BEAT_W'(BURST_LEN - 1)) begin
            state_nxt     = IDLE;
            cmd_nxt.valid = 1'b0;
          end else begin
            beat_nxt     = beat + BEAT_W'(1);
            cmd_nxt.addr = base + ADDR_W'(beat_nxt);
          end
        end
      end
      WR: begin
        if (hs) begin
          wr_ack        = 1'b1;
          state_nxt     = IDLE;
          cmd_nxt.valid = 1'b0;
          cmd_nxt.we    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Keep the handshake pulses quiet while the block is held in reset.
    if (!reset) begin
      rd_grant = 1'b0;
      wr_ack   = 1'b0;
    end
  end

  always_ff @(posedge clk_low) begin
    if (!reset || !wr_req || wr_ack)
      wait_cnt <= '0;
    else if (state != WR && !wr_starved)
      wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk_low) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= mem_rvalid;
      if (mem_rvalid) rd_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: table of read bursts with ready patterns plus hand sequences
// for starvation, simultaneous requests and reset; a scoreboard checks every command and return.
module tb_fb_mem_arbiter;

  localparam int AW = 26;
  localparam int DW = 24;
  localparam int BL = 16;

  logic          clk_low, reset;
  logic          rd_req, rd_grant, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_cmd_valid, mem_cmd_ready, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .WR_MAX_WAIT(64)) dut (
    .clk_low(clk_low), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk_low = 1'b0;
    forever #5 clk_low = ~clk_low;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    pat;   // mem_cmd_ready per valid cycle, bit (n % 4)
    int            cyc;   // expected valid cycles to complete the burst
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            gnt_cnt = 0;
  logic [AW-1:0] rd_cmd_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic          rsp_pend = 1'b0;
  logic [AW-1:0] rsp_addr = '0;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] stall_addr = '0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 24'hA5C3E1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model and scoreboard, sampled on the falling edge.
  always @(negedge clk_low) begin
    if (rd_valid) begin
      if (rd_q.size() == 0) chk("rd_valid_spurious", 64'(rd_valid), 64'(0));
      else chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
    end
    if (mem_rvalid && reset) rd_q.push_back(mem_rdata);
    if (reset && stall_prev) begin
      chk("stall_valid", 64'(mem_cmd_valid), 64'(1));
      chk("stall_addr", 64'(mem_addr), 64'(stall_addr));
    end
    stall_prev = reset && mem_cmd_valid && !mem_cmd_ready;
    stall_addr = mem_addr;
    rsp_pend = 1'b0;
    if (reset && mem_cmd_valid && mem_cmd_ready) begin
      if (mem_we) begin
        if (wr_q.size() == 0) chk("wr_cmd_unexpected", 64'(mem_addr), 64'hDEAD);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_cmd_addr", 64'(mem_addr), 64'(w.addr));
          chk("wr_cmd_data", 64'(mem_wdata), 64'(w.data));
        end
      end else begin
        if (rd_cmd_q.size() == 0) chk("rd_cmd_unexpected", 64'(mem_addr), 64'hDEAD);
        else chk("rd_cmd_addr", 64'(mem_addr), 64'(rd_cmd_q.pop_front()));
        rsp_pend = 1'b1;
        rsp_addr = mem_addr;
      end
    end
    if (rd_grant && reset) begin
      gnt_cnt++;
      for (int i = 0; i < BL; i++) rd_cmd_q.push_back(rd_addr + AW'(i));
    end
  end

  always @(posedge clk_low) begin
    #1;
    mem_rvalid = rsp_pend;
    mem_rdata  = mem_fn(rsp_addr);
  end

  task automatic wait_idle(input string name, input int max);
    bit done = 0;
    for (int t = 0; t < max && !done; t++) begin
      @(negedge clk_low);
      if (!mem_cmd_valid) done = 1;
    end
    if (!done) chk(name, 64'(mem_cmd_valid), 64'(0));
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input logic [3:0] pat, input int exp_cyc);
    int g0 = gnt_cnt;
    int hs = 0;
    int vc = 0;
    @(posedge clk_low); #1;
    rd_req = 1'b1; rd_addr = a; mem_cmd_ready = 1'b1;
    @(negedge clk_low);
    chk("burst_grant", 64'(rd_grant), 64'(1));
    @(posedge clk_low); #1;
    rd_req = 1'b0;
    for (int i = 0; i < 200 && hs < BL; i++) begin
      mem_cmd_ready = pat[i % 4];
      @(negedge clk_low);
      if (mem_cmd_valid) begin
        vc++;
        if (mem_cmd_ready) hs++;
      end
      if (hs < BL) begin @(posedge clk_low); #1; end
    end
    chk("burst_handshakes", 64'(hs), 64'(BL));
    chk("burst_valid_cycles", 64'(vc), 64'(exp_cyc));
    @(posedge clk_low); #1;
    mem_cmd_ready = 1'b1;
    @(negedge clk_low);
    chk("burst_end_valid", 64'(mem_cmd_valid), 64'(0));
    chk("burst_grants", 64'(gnt_cnt - g0), 64'(1));
    chk("burst_sb_empty", 64'(rd_cmd_q.size()), 64'(0));
  endtask

  vec_t tbl[5];

  initial begin
    int ack_t;
    int g0;
    int extra;
    tbl[0] = '{addr: 26'h0000100, pat: 4'b1111, cyc: 16};
    tbl[1] = '{addr: 26'h3FFFFF8, pat: 4'b1111, cyc: 16};
    tbl[2] = '{addr: 26'h0000200, pat: 4'b1001, cyc: 32};
    tbl[3] = '{addr: 26'h0000000, pat: 4'b0101, cyc: 31};
    tbl[4] = '{addr: 26'h3FFFFFF, pat: 4'b0011, cyc: 30};

    reset = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    mem_cmd_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk_low);
    @(negedge clk_low);
    chk("rst_rd_grant", 64'(rd_grant), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_wr_ack", 64'(wr_ack), 64'(0));
    chk("rst_cmd_valid", 64'(mem_cmd_valid), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    @(posedge clk_low); #1;
    reset = 1'b1;

    foreach (tbl[k]) run_burst(tbl[k].addr, tbl[k].pat, tbl[k].cyc);

    // Starvation: both requests held; 4 bursts fit before wait_cnt saturates at 64.
    @(posedge clk_low); #1;
    g0 = gnt_cnt; ack_t = -1;
    rd_req = 1'b1; rd_addr = 26'h1000;
    wr_req = 1'b1; wr_addr = 26'h55; wr_data = 24'hABCDEF;
    wr_q.push_back('{addr: 26'h55, data: 24'hABCDEF});
    for (int t = 0; t < 300 && ack_t < 0; t++) begin
      @(negedge clk_low);
      if (wr_ack) ack_t = t;
    end
    chk("starve_ack_cycle", 64'(ack_t), 64'(69));
    chk("starve_grants", 64'(gnt_cnt - g0), 64'(4));
    @(posedge clk_low); #1;
    wr_req = 1'b0;
    @(negedge clk_low);
    chk("starve_resume_grant", 64'(rd_grant), 64'(1));
    @(posedge clk_low); #1;
    rd_req = 1'b0;
    extra = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_low);
      if (wr_ack) extra++;
    end
    chk("starve_single_ack", 64'(extra), 64'(0));
    chk("starve_rd_sb_empty", 64'(rd_cmd_q.size()), 64'(0));
    chk("starve_wr_sb_empty", 64'(wr_q.size()), 64'(0));

    // Simultaneous requests with wait_cnt=0: read first, dead cycle, then the write.
    @(posedge clk_low); #1;
    ack_t = -1;
    rd_req = 1'b1; rd_addr = 26'h2000;
    wr_req = 1'b1; wr_addr = 26'h66; wr_data = 24'h123456;
    wr_q.push_back('{addr: 26'h66, data: 24'h123456});
    @(negedge clk_low);
    chk("simul_grant", 64'(rd_grant), 64'(1));
    @(posedge clk_low); #1;
    rd_req = 1'b0;
    for (int t = 1; t < 100 && ack_t < 0; t++) begin
      @(negedge clk_low);
      if (t == 17) chk("simul_dead_cycle", 64'(mem_cmd_valid), 64'(0));
      if (wr_ack) ack_t = t;
      if (ack_t < 0) begin @(posedge clk_low); #1; end
    end
    chk("simul_ack_cycle", 64'(ack_t), 64'(18));
    @(posedge clk_low); #1;
    wr_req = 1'b0;
    @(negedge clk_low);
    chk("simul_wr_sb_empty", 64'(wr_q.size()), 64'(0));

    // Reset during beat 7 of a burst, then a fresh burst from the new address.
    @(posedge clk_low); #1;
    rd_req = 1'b1; rd_addr = 26'h400;
    begin
      bit seen = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
        @(negedge clk_low);
        if (mem_cmd_valid && mem_addr == 26'h406) seen = 1;
      end
      chk("rst_reach_beat6", 64'(seen), 64'(1));
    end
    @(posedge clk_low); #1;
    reset = 1'b0; rd_addr = 26'h800;
    @(negedge clk_low);
    @(posedge clk_low); #1;
    @(negedge clk_low);
    chk("midrst_cmd_valid", 64'(mem_cmd_valid), 64'(0));
    chk("midrst_rd_grant", 64'(rd_grant), 64'(0));
    chk("midrst_wr_ack", 64'(wr_ack), 64'(0));
    chk("midrst_rd_valid", 64'(rd_valid), 64'(0));
    rd_cmd_q.delete();
    @(posedge clk_low); #1;
    reset = 1'b1;
    @(negedge clk_low);
    chk("postrst_grant", 64'(rd_grant), 64'(1));
    @(posedge clk_low); #1;
    rd_req = 1'b0;
    @(negedge clk_low);
    chk("postrst_first_addr", 64'(mem_addr), 64'(26'h800));
    wait_idle("postrst_timeout", 60);
    chk("postrst_sb_empty", 64'(rd_cmd_q.size()), 64'(0));

    repeat (4) @(negedge clk_low);
    chk("final_rd_ret_empty", 64'(rd_q.size()), 64'(0));
    chk("final_wr_sb_empty", 64'(wr_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
